// File: rtl/qtrx_sensor_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : qtrx_sensor_emulator_if
//  Description : Configuration write port of the QTRX sensor emulator.
//                A valid/ready handshake that programs one channel's
//                discharge time per accepted transfer.
//                  cfg_valid  host -> emulator  write request
//                  cfg_ready  emulator -> host  write accepted when valid & ready
//                  cfg_ch     host -> emulator  channel to program (0..7)
//                  cfg_ttd    host -> emulator  discharge time in clock cycles
//  Revision    : 1.0  initial release
// ============================================================================
interface qtrx_sensor_emulator_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [16:0] cfg_ttd;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_ttd,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_ttd,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/qtrx_sensor_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : qtrx_sensor_emulator
//  Description : Eight-channel responder model of the QTRX reflectance
//                sensor array. Each channel watches the host's charge drive
//                and, after a long enough charge, holds its line high for a
//                programmed discharge time (or DARK_TTD when its emitter LED
//                is off), then pulses resp_done.
//  Ports       : WF_CLK      system clock, rising edge
//                WF_RST_N    asynchronous active-low reset
//                ir_host_oe  per-channel host charge drive (async, synced)
//                ir_evenLED  emitter enable, channels 0/2/4/6 (async, synced)
//                ir_oddLED   emitter enable, channels 1/3/5/7 (async, synced)
//                ir_drv      per-channel emulator line drive (registered)
//                resp_done   per-channel one-cycle end-of-response pulse
//                cfg         discharge-time programming port (slave)
//  Revision    : 1.0  initial release
// ============================================================================
module qtrx_sensor_emulator #(
    parameter int          MIN_CHARGE  = 100,
    parameter logic [16:0] DEFAULT_TTD = 17'd2000,
    parameter logic [16:0] DARK_TTD    = 17'd60000
) (
    input  wire logic              WF_CLK,
    input  wire logic              WF_RST_N,
    input  wire logic [7:0]        ir_host_oe,
    input  wire logic              ir_evenLED,
    input  wire logic              ir_oddLED,
    output logic [7:0]             ir_drv,
    output logic [7:0]             resp_done,
    qtrx_sensor_emulator_if.slave  cfg
);

    localparam int             c_CW       = $clog2(MIN_CHARGE + 1);
    localparam logic [c_CW-1:0] c_MIN_CHG = c_CW'(MIN_CHARGE);
    localparam logic [c_CW-1:0] c_CHG_ONE = c_CW'(1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CHARGE    = 2'd1;
    localparam logic [1:0] S_DISCHARGE = 2'd2;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous host-side inputs
    // ------------------------------------------------------------------
    logic [7:0] r_oe_meta;
    logic [7:0] r_oe_s;
    logic       r_even_meta;
    logic       r_even_s;
    logic       r_odd_meta;
    logic       r_odd_s;

    always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
        if (!WF_RST_N) begin
            r_oe_meta   <= '0;
            r_oe_s      <= '0;
            r_even_meta <= 1'b0;
            r_even_s    <= 1'b0;
            r_odd_meta  <= 1'b0;
            r_odd_s     <= 1'b0;
        end else begin
            r_oe_meta   <= ir_host_oe;
            r_oe_s      <= r_oe_meta;
            r_even_meta <= ir_evenLED;
            r_even_s    <= r_even_meta;
            r_odd_meta  <= ir_oddLED;
            r_odd_s     <= r_odd_meta;
        end
    end

    // ------------------------------------------------------------------
    // Config port: always ready once out of reset
    // ------------------------------------------------------------------
    logic r_cfg_ready;
    logic w_cfg_fire;

    always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
        if (!WF_RST_N) begin
            r_cfg_ready <= 1'b0;
        end else begin
            r_cfg_ready <= 1'b1;
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign w_cfg_fire    = cfg.cfg_valid & r_cfg_ready;

    // ------------------------------------------------------------------
    // Per-channel responder
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        logic [1:0]      r_state;
        logic [1:0]      w_state_nxt;
        logic [c_CW-1:0] r_chg_cnt;
        logic [c_CW-1:0] w_chg_nxt;
        logic [16:0]     r_dis_cnt;
        logic [16:0]     w_dis_nxt;
        logic [16:0]     r_ttd;
        logic            r_drv;
        logic            w_drv_nxt;
        logic            r_done;
        logic            w_done_nxt;
        logic            w_oe;
        logic            w_led;
        logic            w_armed;
        logic [16:0]     w_load;

        assign w_oe    = r_oe_s[gi];
        assign w_led   = ((gi % 2) == 1) ? r_odd_s : r_even_s;
        assign w_armed = (r_chg_cnt >= c_MIN_CHG);
        // Sampled only on the CHARGE->DISCHARGE edge, so the pulse length
        // is frozen at entry. A config write landing on that same edge
        // is not yet visible in r_ttd, so the old value is used.
        assign w_load  = w_led ? r_ttd : DARK_TTD;

        always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
            if (!WF_RST_N) begin
                r_ttd <= DEFAULT_TTD;
            end else if (w_cfg_fire && (cfg.cfg_ch == 3'(gi))) begin
                r_ttd <= cfg.cfg_ttd;
            end
        end

        // State register
        always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
            if (!WF_RST_N) begin
                r_state   <= S_IDLE;
                r_chg_cnt <= '0;
                r_dis_cnt <= '0;
                r_drv     <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_chg_cnt <= w_chg_nxt;
                r_dis_cnt <= w_dis_nxt;
                r_drv     <= w_drv_nxt;
                r_done    <= w_done_nxt;
            end
        end

        // Next-state logic
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                S_IDLE: begin
                    if (w_oe) begin
                        w_state_nxt = S_CHARGE;
                    end
                end
                S_CHARGE: begin
                    if (!w_oe) begin
                        if (w_armed && (w_load != 17'd0)) begin
                            w_state_nxt = S_DISCHARGE;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_DISCHARGE: begin
                    // A new host charge wins over the natural end of the pulse.
                    if (w_oe) begin
                        w_state_nxt = S_CHARGE;
                    end else if (r_dis_cnt <= 17'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Datapath / output logic
        always_comb begin
            w_chg_nxt  = r_chg_cnt;
            w_dis_nxt  = r_dis_cnt;
            w_done_nxt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_oe) begin
                        w_chg_nxt = c_CHG_ONE;
                    end
                end
                S_CHARGE: begin
                    if (w_oe) begin
                        if (!w_armed) begin
                            w_chg_nxt = r_chg_cnt + c_CHG_ONE;
                        end
                    end else begin
                        w_chg_nxt = '0;
                        if (w_armed) begin
                            if (w_load == 17'd0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_dis_nxt = w_load;
                            end
                        end
                    end
                end
                S_DISCHARGE: begin
                    if (w_oe) begin
                        w_chg_nxt = c_CHG_ONE;
                        w_dis_nxt = '0;
                    end else if (r_dis_cnt <= 17'd1) begin
                        w_dis_nxt  = '0;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_dis_nxt = r_dis_cnt - 17'd1;
                    end
                end
                default: begin
                    w_chg_nxt = '0;
                    w_dis_nxt = '0;
                end
            endcase
            // Drive is a dedicated flop so the line never sees state-decode glitches.
            w_drv_nxt = (w_state_nxt == S_DISCHARGE);
        end

        assign ir_drv[gi]    = r_drv;
        assign resp_done[gi] = r_done;
    end

endmodule
`default_nettype wire
